fll_cfg_arbiter: RTL and testbench
==================================

FLL_CFG_ARBITER -- requirements
Module: fll_cfg_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 2, meaning number of configuration requesters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning maximum cycles spent waiting in REQ or WAIT_ACK_LOW before an abort (>=4).
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_i  input  NB_REQ  per-requester request level, held until the matching ack_o.
REQ-006 SHALL have port wrn_i  input  NB_REQ  per-requester access type, 1 = read, 0 = write.
REQ-007 SHALL have port add_i  input  NB_REQ x 2  per-requester FLL register address.
REQ-008 SHALL have port wdata_i  input  NB_REQ x 32  per-requester write data.
REQ-009 SHALL have port ack_o  output  NB_REQ  one-cycle completion pulse to the served requester.
REQ-010 SHALL have port err_o  output  1  qualifies ack_o; 1 = access aborted by timeout.
REQ-011 SHALL have port rdata_o  output  32  read data, valid only while ack_o is nonzero.
REQ-012 SHALL have port fll_req_o  output  1  FLL configuration request level.
REQ-013 SHALL have port fll_wrn_o  output  1  FLL access type, 1 = read, 0 = write.
REQ-014 SHALL have port fll_add_o  output  2  FLL register address.
REQ-015 SHALL have port fll_wdata_o  output  32  FLL write data.
REQ-016 SHALL have port fll_ack_i  input  1  FLL acknowledge, synchronous to clk, 4-phase with fll_req_o.
REQ-017 SHALL have port fll_rdata_i  input  32  FLL read data, valid while fll_ack_i is high.
REQ-018 SHALL have port busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, REQ, WAIT_ACK_LOW and RESP.
REQ-020 SHALL grant in IDLE using round-robin, with highest priority given to the index after the last granted index; after reset, index 0 has highest priority.
REQ-021 SHALL, on grant in cycle N, latch the granted requester's wrn_i, add_i and wdata_i into the fll_* registers, enter REQ, and drive fll_req_o high from cycle N+1.
REQ-022 SHALL hold fll_wrn_o, fll_add_o and fll_wdata_o stable from grant until the return to IDLE.
REQ-023 SHALL, in REQ when fll_ack_i is sampled high, capture fll_rdata_i, drive fll_req_o low from the next cycle, and enter WAIT_ACK_LOW.
REQ-024 SHALL, in WAIT_ACK_LOW when fll_ack_i is sampled low, enter RESP.
REQ-025 SHALL, in RESP, drive ack_o[granted] high for exactly one cycle with err_o=0 and the captured rdata_o (captured value regardless of access type), then enter IDLE.
REQ-026 SHALL keep a timeout counter that clears on entry to REQ and on entry to WAIT_ACK_LOW and increments on every cycle spent in either state.
REQ-027 SHALL, when the counter reaches TIMEOUT_CYCLES-1, deassert fll_req_o, set rdata_o=32'h0, and enter RESP with err_o=1.
REQ-028 SHALL, after a timeout abort, block any new grant until fll_ack_i has been sampled low.
REQ-029 SHALL mask the just-served requester during the first IDLE cycle after RESP, so that a requester which drops req_i one cycle after ack_o is not re-granted.
REQ-030 SHALL ignore changes on req_i, wrn_i, add_i and wdata_i while not in IDLE.
REQ-031 SHALL grant only on request levels present in IDLE; simultaneous requests are resolved solely by the round-robin pointer.
REQ-032 SHALL have a service latency of 3 cycles from grant to ack_o when fll_ack_i is a single-cycle pulse arriving one cycle after fll_req_o rises.

Reset
REQ-033 SHALL, on rst_n low at any time including mid-transaction, asynchronously force: state IDLE, fll_req_o=0, fll_wrn_o=1, fll_add_o=0, fll_wdata_o=0, ack_o=0, err_o=0, rdata_o=0, busy_o=0, priority pointer=0, timeout counter=0, mask cleared.

Structure
REQ-034 SHALL take the state enum, FLL_ADDR_W=2, FLL_DATA_W=32 and the abort read value 32'h0 from a shared package fll_cfg_pkg.
REQ-035 SHALL place the round-robin grant and pointer logic in one sub-module, rr_arbiter, parameterised by NB_REQ.

Verification
REQ-036 SHALL cover: req_i[0]=1 read, add=2, FLL returns ack pulse with rdata=32'h0000_1234 -> ack_o=01, err_o=0, rdata_o=32'h0000_1234, fll_req_o low before ack_o.
REQ-037 SHALL cover: req_i=11 asserted in the same cycle, both held until ack -> grant order 0 then 1; then req_i=11 again -> order 1 is not repeated first, i.e. 0 then 1.
REQ-038 SHALL cover: write of add=1, wdata=32'hCAFE_0001, with fll_ack_i held high for 5 cycles -> fll_req_o low after the first ack cycle, ack_o only after ack falls, fll_wdata_o stable throughout.
REQ-039 SHALL cover: FLL never acks with TIMEOUT_CYCLES=16 -> ack_o pulse with err_o=1 and rdata_o=0 exactly 16 cycles after fll_req_o rises; a late fll_ack_i then blocks new grants until it falls.
REQ-040 SHALL cover: rst_n asserted while in WAIT_ACK_LOW -> all outputs at reset values immediately, and the next request after release is granted to index 0.

Source files
------------

// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration arbiter.
// The FLL register interface is narrow: a 2-bit address and 32-bit data.
package fll_cfg_pkg;

    localparam int FLL_ADDR_W = 2;
    localparam int FLL_DATA_W = 32;

    // Read data returned to a requester whose access was aborted by timeout.
    localparam logic [FLL_DATA_W-1:0] ABORT_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_REQ          = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2,
        ST_RESP         = 2'd3
    } fll_state_e;

endpackage

// File: rtl/fll_cfg_arbiter_if.sv
// FLL configuration bus between the arbiter (master) and the FLL (slave).
// Handshake is 4-phase: master raises fll_req_o with wrn/add/wdata stable, slave raises
// fll_ack_i (fll_rdata_i valid while high), master drops fll_req_o, slave drops fll_ack_i.
interface fll_cfg_arbiter_if;
    import fll_cfg_pkg::*;

    logic                  fll_req_o;
    logic                  fll_wrn_o;
    logic [FLL_ADDR_W-1:0] fll_add_o;
    logic [FLL_DATA_W-1:0] fll_wdata_o;
    logic                  fll_ack_i;
    logic [FLL_DATA_W-1:0] fll_rdata_i;

    modport master (
        output fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o,
        input  fll_ack_i, fll_rdata_i
    );

    modport slave (
        input  fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o,
        output fll_ack_i, fll_rdata_i
    );

endinterface

// File: rtl/fll_cfg_arbiter_rr.sv
// Round-robin grant selection; the pointer holds the index with highest priority
// and moves to one past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int NB_REQ = 2,
    parameter int IDX_W  = $clog2(NB_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB_REQ-1:0] req,
    input  logic              en,
    output logic              valid,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0]    ptr_q;
    logic [2*NB_REQ-1:0] dbl;
    logic [NB_REQ-1:0]   rot;
    logic [IDX_W:0]      sum;

    // Rotate requests so that bit 0 is the pointer's index, then take the first set bit.
    always_comb begin
        dbl   = {req, req} >> ptr_q;
        rot   = dbl[NB_REQ-1:0];
        valid = 1'b0;
        sum   = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr_q} + (IDX_W+1)'(k);
            end
        end
        if (sum >= (IDX_W+1)'(NB_REQ)) begin
            sum = sum - (IDX_W+1)'(NB_REQ);
        end
        idx = sum[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en && valid) begin
            ptr_q <= (idx == IDX_W'(NB_REQ-1)) ? '0 : idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/fll_cfg_arbiter.sv
// Arbitrates several configuration requesters onto one 4-phase FLL register port,
// with a per-transaction timeout that aborts a stuck handshake.
module fll_cfg_arbiter
    import fll_cfg_pkg::*;
#(
    parameter int NB_REQ         = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NB_REQ-1:0]                req_i,
    input  logic [NB_REQ-1:0]                wrn_i,
    input  logic [NB_REQ-1:0][FLL_ADDR_W-1:0] add_i,
    input  logic [NB_REQ-1:0][FLL_DATA_W-1:0] wdata_i,
    output logic [NB_REQ-1:0]                ack_o,
    output logic                             err_o,
    output logic [FLL_DATA_W-1:0]            rdata_o,
    output logic                             busy_o,
    output fll_state_e                       dbg_state,
    fll_cfg_arbiter_if.master                fll
);

    localparam int IDX_W = $clog2(NB_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fll_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  gnt_q;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [NB_REQ-1:0] mask_q;
    logic [NB_REQ-1:0] req_eff;
    logic [NB_REQ-1:0] gnt_onehot;
    logic              block_q;
    logic              take;
    logic              timeout;

    assign req_eff    = req_i & ~mask_q;
    assign gnt_onehot = NB_REQ'(1) << gnt_q;
    assign timeout    = (cnt_q == CNT_LAST);
    // After an abort the FLL may still be holding ack; no new grant until it is seen low.
    assign take       = (state_q == ST_IDLE) && !(block_q && fll.fll_ack_i);
    assign busy_o     = (state_q != ST_IDLE);
    assign dbg_state  = state_q;

    rr_arbiter #(
        .NB_REQ (NB_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_eff),
        .en    (take),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            gnt_q           <= '0;
            mask_q          <= '0;
            block_q         <= 1'b0;
            ack_o           <= '0;
            err_o           <= 1'b0;
            rdata_o         <= '0;
            fll.fll_req_o   <= 1'b0;
            fll.fll_wrn_o   <= 1'b1;
            fll.fll_add_o   <= '0;
            fll.fll_wdata_o <= '0;
        end else begin
            ack_o <= '0;
            if (!fll.fll_ack_i) begin
                block_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    mask_q <= '0;
                    err_o  <= 1'b0;
                    if (take && arb_valid) begin
                        gnt_q           <= arb_idx;
                        fll.fll_wrn_o   <= wrn_i[arb_idx];
                        fll.fll_add_o   <= add_i[arb_idx];
                        fll.fll_wdata_o <= wdata_i[arb_idx];
                        fll.fll_req_o   <= 1'b1;
                        cnt_q           <= '0;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (fll.fll_ack_i) begin
                        rdata_o       <= fll.fll_rdata_i;
                        fll.fll_req_o <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= ST_WAIT_ACK_LOW;
                    end else if (timeout) begin
                        fll.fll_req_o <= 1'b0;
                        rdata_o       <= ABORT_RDATA;
                        err_o         <= 1'b1;
                        ack_o         <= gnt_onehot;
                        block_q       <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_ACK_LOW: begin
                    if (!fll.fll_ack_i) begin
                        err_o   <= 1'b0;
                        ack_o   <= gnt_onehot;
                        state_q <= ST_RESP;
                    end else if (timeout) begin
                        rdata_o <= ABORT_RDATA;
                        err_o   <= 1'b1;
                        ack_o   <= gnt_onehot;
                        block_q <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Hide the requester just served for one IDLE cycle so its lagging req drop is not re-granted.
                    mask_q  <= gnt_onehot;
                    err_o   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// Directed bench for fll_cfg_arbiter: the bench plays both the requesters and the FLL,
// with every expected value worked out by hand from the handshake timing.
module tb_fll_cfg_arbiter;
    import fll_cfg_pkg::*;

    localparam int NB  = 2;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NB-1:0]     req;
    logic [NB-1:0]     wrn;
    logic [NB-1:0][1:0]  add;
    logic [NB-1:0][31:0] wdata;
    logic [NB-1:0]     ack;
    logic              err;
    logic [31:0]       rdata;
    logic              busy;
    fll_state_e        st;
    int                lat;

    int n_tests = 0;
    int n_fail  = 0;

    fll_cfg_arbiter_if fll_bus();

    fll_cfg_arbiter #(
        .NB_REQ         (NB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .wrn_i     (wrn),
        .add_i     (add),
        .wdata_i   (wdata),
        .ack_o     (ack),
        .err_o     (err),
        .rdata_o   (rdata),
        .busy_o    (busy),
        .dbg_state (st),
        .fll       (fll_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for fll_req_o to rise; returns the number of edges waited.
    task automatic wait_req(input string tag, output int cycles);
        cycles = 0;
        while (fll_bus.fll_req_o !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        chk({tag, "_req_rise"}, 32'(fll_bus.fll_req_o), 32'(1'b1));
    endtask

    // One transaction with a single-cycle FLL ack arriving one cycle after fll_req_o rises.
    task automatic run_pulse(input logic [31:0] rd, input logic [1:0] exp_ack,
                             input logic [1:0] exp_add, input string tag);
        int c;
        wait_req(tag, c);
        chk({tag, "_add"}, 32'(fll_bus.fll_add_o), 32'(exp_add));
        tick();
        fll_bus.fll_ack_i   = 1'b1;
        fll_bus.fll_rdata_i = rd;
        tick();
        chk({tag, "_req_low"}, 32'(fll_bus.fll_req_o), 32'(1'b0));
        fll_bus.fll_ack_i   = 1'b0;
        fll_bus.fll_rdata_i = 32'hDEAD_BEEF;
        tick();
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_err"}, 32'(err), 32'(1'b0));
        chk({tag, "_rdata"}, rdata, rd);
        req = req & ~exp_ack;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = '0;
        wrn   = '0;
        add   = '0;
        wdata = '0;
        fll_bus.fll_ack_i   = 1'b0;
        fll_bus.fll_rdata_i = '0;
        repeat (3) tick();
        chk("rst_fll_req", 32'(fll_bus.fll_req_o), 32'(1'b0));
        chk("rst_fll_wrn", 32'(fll_bus.fll_wrn_o), 32'(1'b1));
        chk("rst_fll_add", 32'(fll_bus.fll_add_o), 32'(2'd0));
        chk("rst_fll_wdata", fll_bus.fll_wdata_o, 32'h0);
        chk("rst_ack", 32'(ack), 32'(2'b00));
        chk("rst_err", 32'(err), 32'(1'b0));
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_state", 32'(st), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // Simultaneous requests: 0 then 1, twice.
        wrn      = 2'b00;
        add[0]   = 2'd2;
        add[1]   = 2'd1;
        wdata[0] = 32'h1111_0000;
        wdata[1] = 32'h2222_0000;
        req      = 2'b11;
        run_pulse(32'h0000_00A0, 2'b01, 2'd2, "rr_a0");
        run_pulse(32'h0000_00A1, 2'b10, 2'd1, "rr_a1");
        req = 2'b11;
        run_pulse(32'h0000_00B0, 2'b01, 2'd2, "rr_b0");
        run_pulse(32'h0000_00B1, 2'b10, 2'd1, "rr_b1");

        // Single read with a one-cycle ack pulse; ack_o lands three edges after the grant edge.
        req    = 2'b01;
        wrn[0] = 1'b1;
        add[0] = 2'd2;
        wait_req("rd", lat);
        chk("rd_grant_lat", 32'(lat), 32'(1));
        chk("rd_wrn", 32'(fll_bus.fll_wrn_o), 32'(1'b1));
        chk("rd_add", 32'(fll_bus.fll_add_o), 32'(2'd2));
        chk("rd_busy", 32'(busy), 32'(1'b1));
        tick();
        fll_bus.fll_ack_i   = 1'b1;
        fll_bus.fll_rdata_i = 32'h0000_1234;
        tick();
        chk("rd_req_low", 32'(fll_bus.fll_req_o), 32'(1'b0));
        chk("rd_ack_early", 32'(ack), 32'(2'b00));
        chk("rd_state_wait", 32'(st), 32'(ST_WAIT_ACK_LOW));
        fll_bus.fll_ack_i   = 1'b0;
        fll_bus.fll_rdata_i = 32'hDEAD_BEEF;
        tick();
        chk("rd_ack", 32'(ack), 32'(2'b01));
        chk("rd_err", 32'(err), 32'(1'b0));
        chk("rd_rdata", rdata, 32'h0000_1234);
        chk("rd_fll_req", 32'(fll_bus.fll_req_o), 32'(1'b0));
        req = 2'b00;
        tick();
        chk("rd_ack_pulse", 32'(ack), 32'(2'b00));
        chk("rd_idle", 32'(busy), 32'(1'b0));
        tick();

        // Write with ack held for five cycles; requester inputs change mid-transaction.
        req      = 2'b01;
        wrn[0]   = 1'b0;
        add[0]   = 2'd1;
        wdata[0] = 32'hCAFE_0001;
        wait_req("wr", lat);
        chk("wr_wrn", 32'(fll_bus.fll_wrn_o), 32'(1'b0));
        chk("wr_add", 32'(fll_bus.fll_add_o), 32'(2'd1));
        chk("wr_wdata", fll_bus.fll_wdata_o, 32'hCAFE_0001);
        add[0]   = 2'd3;
        wdata[0] = 32'hFFFF_FFFF;
        wrn[0]   = 1'b1;
        tick();
        fll_bus.fll_ack_i   = 1'b1;
        fll_bus.fll_rdata_i = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wr_req_low", 32'(fll_bus.fll_req_o), 32'(1'b0));
            chk("wr_ack_held", 32'(ack), 32'(2'b00));
            chk("wr_wdata_hold", fll_bus.fll_wdata_o, 32'hCAFE_0001);
        end
        fll_bus.fll_ack_i = 1'b0;
        tick();
        chk("wr_ack", 32'(ack), 32'(2'b01));
        chk("wr_err", 32'(err), 32'(1'b0));
        chk("wr_rdata", rdata, 32'h5555_AAAA);
        chk("wr_wdata_end", fll_bus.fll_wdata_o, 32'hCAFE_0001);
        chk("wr_add_end", 32'(fll_bus.fll_add_o), 32'(2'd1));
        chk("wr_wrn_end", 32'(fll_bus.fll_wrn_o), 32'(1'b0));
        req = 2'b00;
        tick();
        tick();

        // FLL never acks: abort 16 cycles after fll_req_o rises, then a late ack blocks grants.
        req    = 2'b10;
        wrn[1] = 1'b1;
        add[1] = 2'd3;
        wait_req("tmo", lat);
        for (int i = 1; i < TMO; i++) begin
            tick();
            chk("tmo_pending", 32'(ack), 32'(2'b00));
        end
        tick();
        chk("tmo_ack", 32'(ack), 32'(2'b10));
        chk("tmo_err", 32'(err), 32'(1'b1));
        chk("tmo_rdata", rdata, 32'h0);
        chk("tmo_fll_req", 32'(fll_bus.fll_req_o), 32'(1'b0));
        fll_bus.fll_ack_i = 1'b1;
        req      = 2'b01;
        wrn[0]   = 1'b0;
        add[0]   = 2'd3;
        wdata[0] = 32'h0BAD_F00D;
        tick();
        chk("tmo_ack_clear", 32'(ack), 32'(2'b00));
        chk("tmo_err_clear", 32'(err), 32'(1'b0));
        tick();
        chk("tmo_block1", 32'(busy), 32'(1'b0));
        tick();
        chk("tmo_block2", 32'(busy), 32'(1'b0));
        fll_bus.fll_ack_i = 1'b0;
        tick();
        chk("tmo_unblock_req", 32'(fll_bus.fll_req_o), 32'(1'b1));
        chk("tmo_unblock_add", 32'(fll_bus.fll_add_o), 32'(2'd3));

        // Reset while in WAIT_ACK_LOW, then index 0 wins again.
        tick();
        fll_bus.fll_ack_i   = 1'b1;
        fll_bus.fll_rdata_i = 32'h7777_0000;
        tick();
        chk("mr_state", 32'(st), 32'(ST_WAIT_ACK_LOW));
        chk("mr_rdata_pre", rdata, 32'h7777_0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_state_rst", 32'(st), 32'(ST_IDLE));
        chk("mr_fll_wrn", 32'(fll_bus.fll_wrn_o), 32'(1'b1));
        chk("mr_fll_add", 32'(fll_bus.fll_add_o), 32'(2'd0));
        chk("mr_fll_wdata", fll_bus.fll_wdata_o, 32'h0);
        chk("mr_fll_req", 32'(fll_bus.fll_req_o), 32'(1'b0));
        chk("mr_ack", 32'(ack), 32'(2'b00));
        chk("mr_err", 32'(err), 32'(1'b0));
        chk("mr_rdata", rdata, 32'h0);
        chk("mr_busy", 32'(busy), 32'(1'b0));
        fll_bus.fll_ack_i = 1'b0;
        req = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        wrn    = 2'b00;
        add[0] = 2'd2;
        add[1] = 2'd1;
        req    = 2'b11;
        run_pulse(32'h0000_00C0, 2'b01, 2'd2, "post_rst0");
        run_pulse(32'h0000_00C1, 2'b10, 2'd1, "post_rst1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
